// File: rtl/commit_wide_pkg.sv
// Shared definitions for the wide commit stage.
//   RB / RP / IDW      : rename bits, physical copies per arch reg, entry width
//   OFS_*              : bit offsets of the reorder-entry fields (LSB = isMret)
//   CAUSE_*            : mcause codes for synchronous exceptions and interrupts
//   commitState_e      : commit FSM states
//   trapMstatus / xretMstatus : mstatus rewrite on trap entry and on mret
package commit_wide_pkg;

  localparam int RB  = 2;
  localparam int RP  = 1 << RB;
  localparam int IDW = 64 + 5 + RB + 6;

  // Entry layout, MSB first: pc, rd arch, rd phy, isBranch, isSu, isCsr,
  // isEcall, isEbreak, isMret.
  localparam int OFS_MRET   = 0;
  localparam int OFS_EBREAK = 1;
  localparam int OFS_ECALL  = 2;
  localparam int OFS_CSR    = 3;
  localparam int OFS_SU     = 4;
  localparam int OFS_BRANCH = 5;
  localparam int OFS_PHY    = 6;
  localparam int OFS_ARCH   = 6 + RB;
  localparam int OFS_PC     = 11 + RB;

  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
  localparam logic [63:0] CAUSE_EBREAK  = 64'd3;
  localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_MSI     = 64'h8000_0000_0000_0003;
  localparam logic [63:0] CAUSE_MEI     = 64'h8000_0000_0000_000B;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } commitState_e;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  function automatic logic [63:0] trapMstatus(input logic [63:0] s);
    logic [63:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // mret: MIE <= MPIE, MPIE <= 1, MPP stays M (only M-mode is implemented).
  function automatic logic [63:0] xretMstatus(input logic [63:0] s);
    logic [63:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/commit_lane.sv
// Decoder for one reorder-buffer entry.
//   entry    : packed reorder info (layout in commit_wide_pkg)
//   wbLog    : write-back done flags, index {arch, phy}
//   pc, rdArch, rdPhy, is* : decoded fields
//   wbDone   : destination physical register has been written back
//   isSerial : entry must retire alone at the head (branch/su/csr/system)
module commit_lane
  import commit_wide_pkg::*;
(
  input  logic [IDW-1:0]   entry,
  input  logic [32*RP-1:0] wbLog,
  output logic [63:0]      pc,
  output logic [4:0]       rdArch,
  output logic [RB-1:0]    rdPhy,
  output logic             isBranch,
  output logic             isSu,
  output logic             isCsr,
  output logic             isEcall,
  output logic             isEbreak,
  output logic             isMret,
  output logic             isSerial,
  output logic             wbDone
);

  assign pc       = entry[OFS_PC +: 64];
  assign rdArch   = entry[OFS_ARCH +: 5];
  assign rdPhy    = entry[OFS_PHY +: RB];
  assign isBranch = entry[OFS_BRANCH];
  assign isSu     = entry[OFS_SU];
  assign isCsr    = entry[OFS_CSR];
  assign isEcall  = entry[OFS_ECALL];
  assign isEbreak = entry[OFS_EBREAK];
  assign isMret   = entry[OFS_MRET];
  assign isSerial = |entry[OFS_BRANCH:OFS_MRET];
  assign wbDone   = wbLog[{rdArch, rdPhy}];

endmodule

// File: rtl/commit_wide.sv
// Superscalar in-order commit stage: retires up to CW reorder entries per
// cycle, updates the architectural rename map, frees old physical copies and
// raises a registered one-cycle redirect/trap pulse for head exceptions.
// Ports:
//   CLK, RSTn                : clock, async active-low reset
//   rob_entry/rob_valid      : CW head entries (lane 0 oldest), thermometer valid
//   rob_pop                  : thermometer of entries retired this cycle
//   isMisPredict             : lane-0 branch was mispredicted
//   wbLog_qout / *_commit_rst: write-back flags in, one-hot frees out
//   archi_X_qout / _dnxt     : current / next architectural map
//   *ILP_ready               : lane-0 su/branch/csr retiring
//   commit_abort, commit_pc, isTrap, isXRet, privileged_pc : registered redirect
//   csr_except_we, *_except_in : registered CSR updates
//   *_csr_out                : current CSR values
//   instret_cnt              : retired-instruction count (COMMIT_INSTRET_EN)
//   fsmState                 : current FSM state for observation
// Build option: define COMMIT_INSTRET_EN to include the 64-bit instret counter;
// otherwise instret_cnt is tied to zero.
// Handshake: rob_pop[i] asserted means lane i is consumed at the next CLK edge;
// the reorder FIFO must present the next entries in the following cycle.
module commit_wide
  import commit_wide_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [CW*IDW-1:0] rob_entry,
  input  logic [CW-1:0]     rob_valid,
  output logic [CW-1:0]     rob_pop,
  input  logic              isMisPredict,
  input  logic [32*RP-1:0]  wbLog_qout,
  output logic [32*RP-1:0]  wbLog_commit_rst,
  output logic [32*RP-1:0]  rnBufU_commit_rst,
  input  logic [32*RB-1:0]  archi_X_qout,
  output logic [32*RB-1:0]  archi_X_dnxt,
  output logic              suILP_ready,
  output logic              bruILP_ready,
  output logic              csrILP_ready,
  output logic              commit_abort,
  output logic [63:0]       commit_pc,
  output logic              isTrap,
  output logic              isXRet,
  output logic [63:0]       privileged_pc,
  output logic              csr_except_we,
  output logic [63:0]       mstatus_except_in,
  output logic [63:0]       mcause_except_in,
  output logic [63:0]       mepc_except_in,
  output logic [63:0]       mtval_except_in,
  input  logic [63:0]       mstatus_csr_out,
  input  logic [63:0]       mip_csr_out,
  input  logic [63:0]       mie_csr_out,
  input  logic [63:0]       mepc_csr_out,
  input  logic [63:0]       mtvec_csr_out,
  output logic [63:0]       instret_cnt,
  output commitState_e      fsmState
);

  commitState_e state, stateNext;

  logic [CW-1:0][63:0]    lanePc;
  logic [CW-1:0][4:0]     laneArch;
  logic [CW-1:0][RB-1:0]  lanePhy;
  logic [CW-1:0] laneBranch, laneSu, laneCsr, laneEcall, laneEbreak, laneMret;
  logic [CW-1:0] laneSerial, laneWbDone;
  logic [CW-1:0] retire;

  for (genvar g = 0; g < CW; g++) begin : g_lane
    commit_lane u_lane (
      .entry    (rob_entry[g*IDW +: IDW]),
      .wbLog    (wbLog_qout),
      .pc       (lanePc[g]),
      .rdArch   (laneArch[g]),
      .rdPhy    (lanePhy[g]),
      .isBranch (laneBranch[g]),
      .isSu     (laneSu[g]),
      .isCsr    (laneCsr[g]),
      .isEcall  (laneEcall[g]),
      .isEbreak (laneEbreak[g]),
      .isMret   (laneMret[g]),
      .isSerial (laneSerial[g]),
      .wbDone   (laneWbDone[g])
    );
  end

  // Only some lane fields and CSR bits matter beyond lane 0.
  logic unusedBits;
  assign unusedBits = ^{lanePc, laneSu, laneCsr, laneEcall, laneEbreak,
                        laneMret, laneBranch, mip_csr_out, mie_csr_out};

  // Head events, strictly prioritised. Nothing is evaluated without a head.
  logic headValid, intExt, intSoft, intTimer, intAny;
  logic evInt, evEcall, evEbreak, evMret, evMisp, evTrap, evAbort;
  logic [63:0] trapCause;

  assign headValid = (state == ST_RUN) && rob_valid[0];
  assign intExt    = mip_csr_out[11] & mie_csr_out[11];
  assign intSoft   = mip_csr_out[3]  & mie_csr_out[3];
  assign intTimer  = mip_csr_out[7]  & mie_csr_out[7];
  assign intAny    = mstatus_csr_out[3] & (intExt | intSoft | intTimer);

  assign evInt    = headValid & intAny;
  assign evEcall  = headValid & ~intAny & laneEcall[0];
  assign evEbreak = headValid & ~intAny & ~laneEcall[0] & laneEbreak[0];
  assign evMret   = headValid & ~intAny & ~laneEcall[0] & ~laneEbreak[0] & laneMret[0];
  assign evMisp   = headValid & ~intAny & ~laneEcall[0] & ~laneEbreak[0] & ~laneMret[0]
                  & laneBranch[0] & isMisPredict & laneWbDone[0];
  assign evTrap   = evInt | evEcall | evEbreak;
  assign evAbort  = evTrap | evMret | evMisp;

  always_comb begin
    trapCause = '0;
    if (evInt) begin
      if (intExt)       trapCause = CAUSE_MEI;
      else if (intSoft) trapCause = CAUSE_MSI;
      else              trapCause = CAUSE_MTI;
    end else if (evEcall) begin
      trapCause = CAUSE_ECALL_M;
    end else if (evEbreak) begin
      trapCause = CAUSE_EBREAK;
    end
  end

  // Retire chain. A younger lane only retires when every older lane does,
  // and it may not share a destination with any of them so that a single
  // map write per register is enough.
  always_comb begin
    logic chain;
    logic ok;
    retire = '0;
    chain  = 1'b1;
    ok     = 1'b0;
    if (state == ST_RUN) begin
      if (evAbort) begin
        retire[0] = evMret | evMisp;
      end else begin
        for (int i = 0; i < CW; i++) begin
          ok = chain & rob_valid[i] & laneWbDone[i];
          if (i > 0) begin
            ok = ok & ~laneSerial[i];
            for (int j = 0; j < i; j++) begin
              if (laneArch[j] == laneArch[i]) ok = 1'b0;
            end
          end
          retire[i] = ok;
          chain     = ok;
        end
      end
    end
  end

  always_comb begin
    archi_X_dnxt     = archi_X_qout;
    wbLog_commit_rst = '0;
    for (int i = 0; i < CW; i++) begin
      if (retire[i]) begin
        archi_X_dnxt[laneArch[i]*RB +: RB] = lanePhy[i];
        wbLog_commit_rst[{laneArch[i], archi_X_qout[laneArch[i]*RB +: RB]}] = 1'b1;
      end
    end
  end

  assign rnBufU_commit_rst = wbLog_commit_rst;
  assign rob_pop           = retire;
  assign suILP_ready       = retire[0] & laneSu[0];
  assign bruILP_ready      = retire[0] & laneBranch[0];
  assign csrILP_ready      = retire[0] & laneCsr[0];
  assign fsmState          = state;

  // FSM: an abort always costs exactly one REDIRECT cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_RUN;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = ST_RUN;
    if (state == ST_RUN && evAbort) stateNext = ST_REDIRECT;
  end

  // Redirect pulses: evAbort can only be high in RUN, so the pulses drop
  // automatically during the REDIRECT cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      commit_abort      <= 1'b0;
      isTrap            <= 1'b0;
      isXRet            <= 1'b0;
      csr_except_we     <= 1'b0;
      commit_pc         <= '0;
      privileged_pc     <= '0;
      mstatus_except_in <= '0;
      mcause_except_in  <= '0;
      mepc_except_in    <= '0;
      mtval_except_in   <= '0;
    end else begin
      commit_abort  <= evAbort;
      isTrap        <= evTrap;
      isXRet        <= evMret;
      csr_except_we <= evTrap | evMret;
      if (evAbort) begin
        commit_pc         <= lanePc[0];
        privileged_pc     <= evTrap ? mtvec_csr_out : (evMret ? mepc_csr_out : '0);
        mstatus_except_in <= evTrap ? trapMstatus(mstatus_csr_out)
                           : (evMret ? xretMstatus(mstatus_csr_out) : '0);
        mcause_except_in  <= trapCause;
        mepc_except_in    <= (evTrap | evMret) ? lanePc[0] : '0;
        mtval_except_in   <= '0;
      end
    end
  end

`ifdef COMMIT_INSTRET_EN
  logic [63:0] instretQ;
  logic [2:0]  popCnt;

  always_comb begin
    popCnt = '0;
    for (int i = 0; i < CW; i++) popCnt = popCnt + {2'b00, retire[i]};
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) instretQ <= '0;
    else       instretQ <= instretQ + {61'd0, popCnt};
  end

  assign instret_cnt = instretQ;
`else
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_commit_wide.sv
// Bench for commit_wide: directed scenarios followed by random traffic. A
// reference model derived from the retire/abort rules pushes expectations into
// queues; a negedge monitor pops and compares every cycle.
module tb_commit_wide;
  import commit_wide_pkg::*;

  localparam int CW = 2;
  localparam int EV_NONE = 0, EV_INT = 1, EV_ECALL = 2, EV_EBREAK = 3,
                 EV_MRET = 4, EV_MISP = 5;
  localparam logic [5:0] F_BR = 6'b100000, F_SU = 6'b010000, F_CSR = 6'b001000,
                         F_ECALL = 6'b000100, F_EBREAK = 6'b000010, F_MRET = 6'b000001;

  logic              CLK, RSTn;
  logic [CW*IDW-1:0] rob_entry;
  logic [CW-1:0]     rob_valid, rob_pop;
  logic              isMisPredict;
  logic [32*RP-1:0]  wbLog_qout, wbLog_commit_rst, rnBufU_commit_rst;
  logic [32*RB-1:0]  archi_X_qout, archi_X_dnxt;
  logic              suILP_ready, bruILP_ready, csrILP_ready;
  logic              commit_abort, isTrap, isXRet, csr_except_we;
  logic [63:0]       commit_pc, privileged_pc;
  logic [63:0]       mstatus_except_in, mcause_except_in, mepc_except_in, mtval_except_in;
  logic [63:0]       mstatus_csr_out, mip_csr_out, mie_csr_out, mepc_csr_out, mtvec_csr_out;
  logic [63:0]       instret_cnt;
  commitState_e      fsmState;

  commit_wide #(.CW(CW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .rob_entry(rob_entry), .rob_valid(rob_valid), .rob_pop(rob_pop),
    .isMisPredict(isMisPredict),
    .wbLog_qout(wbLog_qout), .wbLog_commit_rst(wbLog_commit_rst),
    .rnBufU_commit_rst(rnBufU_commit_rst),
    .archi_X_qout(archi_X_qout), .archi_X_dnxt(archi_X_dnxt),
    .suILP_ready(suILP_ready), .bruILP_ready(bruILP_ready), .csrILP_ready(csrILP_ready),
    .commit_abort(commit_abort), .commit_pc(commit_pc),
    .isTrap(isTrap), .isXRet(isXRet), .privileged_pc(privileged_pc),
    .csr_except_we(csr_except_we),
    .mstatus_except_in(mstatus_except_in), .mcause_except_in(mcause_except_in),
    .mepc_except_in(mepc_except_in), .mtval_except_in(mtval_except_in),
    .mstatus_csr_out(mstatus_csr_out), .mip_csr_out(mip_csr_out),
    .mie_csr_out(mie_csr_out), .mepc_csr_out(mepc_csr_out),
    .mtvec_csr_out(mtvec_csr_out),
    .instret_cnt(instret_cnt), .fsmState(fsmState)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic              abort;
    logic [CW-1:0]     pop;
    logic [32*RB-1:0]  dnxt;
    logic [32*RP-1:0]  rst;
    logic [2:0]        ilp;   // {bru, su, csr}
    logic [63:0]       instret;
  } exp_t;

  typedef struct packed {
    logic        trap;
    logic        xret;
    logic        we;
    logic [63:0] pc;
    logic [63:0] ppc;
    logic [63:0] mstatus;
    logic [63:0] mcause;
    logic [63:0] mepc;
  } trap_t;

  exp_t  exp_q[$];
  trap_t trap_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  logic              in_redirect = 1'b0;
  logic [63:0]       exp_instret = '0;
  logic [32*RB-1:0]  model_map = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [IDW-1:0] mk_entry(input logic [63:0] pc, input logic [4:0] arch,
                                              input logic [RB-1:0] phy, input logic [5:0] f);
    return {pc, arch, phy, f};
  endfunction

  // ---------------- reference model ----------------
  task automatic model_step();
    exp_t           e;
    trap_t          t;
    logic [IDW-1:0] ent;
    logic [63:0]    lpc [CW];
    logic [4:0]     ar  [CW];
    logic [RB-1:0]  ph  [CW];
    logic [5:0]     fl  [CW];
    logic           dn  [CW];
    logic [63:0]    pend, m;
    int             ev, n_ret;
    logic           dup;
    e = '0;
    t = '0;
    e.abort   = in_redirect;
    e.dnxt    = archi_X_qout;
    e.instret = exp_instret;
    for (int i = 0; i < CW; i++) begin
      ent    = rob_entry[i*IDW +: IDW];
      lpc[i] = ent[IDW-1 -: 64];
      ar[i]  = ent[IDW-65 -: 5];
      ph[i]  = ent[5+RB -: RB];
      fl[i]  = ent[5:0];
      dn[i]  = wbLog_qout[int'(ar[i])*RP + int'(ph[i])];
    end
    ev = EV_NONE;
    n_ret = 0;
    pend = mip_csr_out & mie_csr_out & 64'h888;
    if (!in_redirect && rob_valid[0]) begin
      if (mstatus_csr_out[3] && pend != 0) ev = EV_INT;
      else if (fl[0][2])                  ev = EV_ECALL;
      else if (fl[0][1])                  ev = EV_EBREAK;
      else if (fl[0][0])                  ev = EV_MRET;
      else if (fl[0][5] && isMisPredict && dn[0]) ev = EV_MISP;
      if (ev == EV_NONE) begin
        for (int i = 0; i < CW; i++) begin
          if (!rob_valid[i] || !dn[i]) break;
          if (i > 0) begin
            if (fl[i] != 6'd0) break;
            dup = 1'b0;
            for (int j = 0; j < i; j++) if (ar[j] == ar[i]) dup = 1'b1;
            if (dup) break;
          end
          n_ret++;
        end
      end else if (ev == EV_MRET || ev == EV_MISP) begin
        n_ret = 1;
      end
    end
    for (int i = 0; i < n_ret; i++) begin
      e.pop[i] = 1'b1;
      e.dnxt[int'(ar[i])*RB +: RB] = ph[i];
      e.rst[int'(ar[i])*RP + int'(archi_X_qout[int'(ar[i])*RB +: RB])] = 1'b1;
    end
    if (n_ret > 0) e.ilp = {fl[0][5], fl[0][4], fl[0][3]};
    if (ev != EV_NONE) begin
      m      = mstatus_csr_out;
      t.trap = (ev == EV_INT || ev == EV_ECALL || ev == EV_EBREAK);
      t.xret = (ev == EV_MRET);
      t.we   = t.trap | t.xret;
      t.pc   = lpc[0];
      t.ppc  = t.trap ? mtvec_csr_out : (t.xret ? mepc_csr_out : 64'd0);
      t.mepc = t.we ? lpc[0] : 64'd0;
      if (t.trap)
        t.mstatus = (m & ~64'h1888) | (((m >> 3) & 64'd1) << 7) | (64'd3 << 11);
      else if (t.xret)
        t.mstatus = (m & ~64'h1888) | (((m >> 7) & 64'd1) << 3) | (64'd1 << 7) | (64'd3 << 11);
      if (ev == EV_INT)
        t.mcause = (64'd1 << 63) | (pend[11] ? 64'd11 : (pend[3] ? 64'd3 : 64'd7));
      else if (ev == EV_ECALL)  t.mcause = 64'd11;
      else if (ev == EV_EBREAK) t.mcause = 64'd3;
      trap_q.push_back(t);
    end
    exp_q.push_back(e);
    model_map   = e.dnxt;
    in_redirect = (ev != EV_NONE);
`ifdef COMMIT_INSTRET_EN
    exp_instret = exp_instret + 64'(n_ret);
`endif
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin : mon
    exp_t  e;
    trap_t t;
    if (RSTn && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("commit_abort", commit_abort, e.abort);
      chk("fsm_state", fsmState, e.abort ? ST_REDIRECT : ST_RUN);
      chk("rob_pop", rob_pop, e.pop);
      chk("archi_X_dnxt", archi_X_dnxt, e.dnxt);
      chk("wbLog_commit_rst", wbLog_commit_rst, e.rst);
      chk("rnBufU_commit_rst", rnBufU_commit_rst, e.rst);
      chk("ilp_ready", {bruILP_ready, suILP_ready, csrILP_ready}, e.ilp);
      chk("instret_cnt", instret_cnt, e.instret);
      if (!commit_abort) begin
        chk("isTrap_idle", isTrap, 1'b0);
        chk("csr_we_idle", csr_except_we, 1'b0);
      end else if (trap_q.size() == 0) begin
        chk("unexpected_abort", 1'b1, 1'b0);
      end else begin
        t = trap_q.pop_front();
        chk("isTrap", isTrap, t.trap);
        chk("isXRet", isXRet, t.xret);
        chk("csr_except_we", csr_except_we, t.we);
        chk("commit_pc", commit_pc, t.pc);
        chk("privileged_pc", privileged_pc, t.ppc);
        chk("mstatus_except_in", mstatus_except_in, t.mstatus);
        chk("mcause_except_in", mcause_except_in, t.mcause);
        chk("mepc_except_in", mepc_except_in, t.mepc);
        chk("mtval_except_in", mtval_except_in, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic commit_cycle();
    archi_X_qout = model_map;
    model_step();
  endtask

  task automatic quiet_inputs();
    rob_entry       = '0;
    rob_valid       = '0;
    isMisPredict    = 1'b0;
    wbLog_qout      = '1;
    mstatus_csr_out = '0;
    mip_csr_out     = '0;
    mie_csr_out     = '0;
    mepc_csr_out    = 64'h0000_0000_8000_0400;
    mtvec_csr_out   = 64'h0000_0000_8000_0000;
  endtask

  task automatic rand_inputs();
    logic [5:0]    f;
    logic [4:0]    ar;
    logic [RB-1:0] ph;
    int            nv;
    for (int i = 0; i < CW; i++) begin
      f = '0;
      for (int b = 0; b < 6; b++) f[b] = ($urandom_range(0, 15) == 0);
      ar = $urandom_range(0, 7);
      ph = $urandom_range(0, RP-1);
      rob_entry[i*IDW +: IDW] = mk_entry({$urandom, $urandom}, ar, ph, f);
    end
    nv = $urandom_range(0, CW);
    rob_valid = '0;
    for (int i = 0; i < nv; i++) rob_valid[i] = 1'b1;
    for (int k = 0; k < 32*RP; k += 32) wbLog_qout[k +: 32] = ~($urandom & $urandom);
    isMisPredict    = $urandom_range(0, 1);
    mstatus_csr_out = {$urandom, $urandom};
    mip_csr_out     = ($urandom_range(0, 5) == 0) ? {$urandom, $urandom} : 64'd0;
    mie_csr_out     = {$urandom, $urandom};
    mepc_csr_out    = {$urandom, $urandom};
    mtvec_csr_out   = {$urandom, $urandom};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RSTn = 1'b0;
    quiet_inputs();
    archi_X_qout = model_map;
    #12;
    chk("rst_commit_abort", commit_abort, 1'b0);
    chk("rst_isTrap", isTrap, 1'b0);
    chk("rst_privileged_pc", privileged_pc, 64'd0);
    chk("rst_instret", instret_cnt, 64'd0);
    chk("rst_state", fsmState, ST_RUN);
    @(negedge CLK);
    RSTn = 1'b1;

    // idle cycle
    next_cycle(); quiet_inputs(); commit_cycle();

    // two independent lanes retire together
    next_cycle(); quiet_inputs();
    rob_entry = {mk_entry(64'h1004, 5'd6, 2'd2, 6'd0), mk_entry(64'h1000, 5'd5, 2'd1, 6'd0)};
    rob_valid = 2'b11;
    commit_cycle();

    // same destination: only lane 0, then the other the next cycle
    next_cycle(); quiet_inputs();
    rob_entry = {mk_entry(64'h100c, 5'd7, 2'd2, 6'd0), mk_entry(64'h1008, 5'd7, 2'd3, 6'd0)};
    rob_valid = 2'b11;
    commit_cycle();
    next_cycle(); quiet_inputs();
    rob_entry = {mk_entry(64'h1010, 5'd8, 2'd1, F_SU), mk_entry(64'h100c, 5'd7, 2'd2, F_CSR)};
    rob_valid = 2'b11;
    commit_cycle();

    // ecall at the head
    next_cycle(); quiet_inputs();
    rob_entry = {mk_entry(64'h8000_0104, 5'd9, 2'd1, 6'd0),
                 mk_entry(64'h8000_0100, 5'd0, 2'd1, F_ECALL)};
    rob_valid = 2'b11;
    mstatus_csr_out = 64'h8;
    commit_cycle();
    next_cycle(); quiet_inputs();
    rob_entry = {mk_entry(64'h2004, 5'd3, 2'd1, 6'd0), mk_entry(64'h2000, 5'd2, 2'd1, 6'd0)};
    rob_valid = 2'b11;
    commit_cycle();

    // timer interrupt wins over a simultaneous ecall
    next_cycle(); quiet_inputs();
    rob_entry = {mk_entry(64'h3004, 5'd3, 2'd2, 6'd0), mk_entry(64'h3000, 5'd1, 2'd1, F_ECALL)};
    rob_valid = 2'b11;
    mie_csr_out = 64'h80; mip_csr_out = 64'h80; mstatus_csr_out = 64'h8;
    commit_cycle();
    next_cycle(); quiet_inputs(); commit_cycle();

    // mret with MPIE set
    next_cycle(); quiet_inputs();
    rob_entry = {mk_entry(64'h4004, 5'd3, 2'd3, 6'd0), mk_entry(64'h4000, 5'd4, 2'd3, F_MRET)};
    rob_valid = 2'b11;
    mstatus_csr_out = 64'h80;
    commit_cycle();
    next_cycle(); quiet_inputs(); commit_cycle();

    // mispredicted branch retires lane 0 only, then back to RUN
    next_cycle(); quiet_inputs();
    rob_entry = {mk_entry(64'h5004, 5'd10, 2'd2, 6'd0), mk_entry(64'h5000, 5'd9, 2'd1, F_BR)};
    rob_valid = 2'b11;
    isMisPredict = 1'b1;
    commit_cycle();
    next_cycle(); quiet_inputs();
    rob_entry = {mk_entry(64'h5104, 5'd12, 2'd2, 6'd0), mk_entry(64'h5100, 5'd11, 2'd1, 6'd0)};
    rob_valid = 2'b11;
    commit_cycle();
    next_cycle(); quiet_inputs();
    rob_entry = {mk_entry(64'h5104, 5'd12, 2'd2, 6'd0), mk_entry(64'h5100, 5'd11, 2'd1, 6'd0)};
    rob_valid = 2'b11;
    commit_cycle();

    // reset asserted while in REDIRECT
    next_cycle(); quiet_inputs();
    rob_entry = {mk_entry(64'h6004, 5'd1, 2'd1, 6'd0), mk_entry(64'h6000, 5'd1, 2'd2, F_EBREAK)};
    rob_valid = 2'b01;
    commit_cycle();
    next_cycle(); quiet_inputs(); commit_cycle();
    @(negedge CLK);
    #1;
    RSTn = 1'b0;
    #1;
    chk("rstmid_commit_abort", commit_abort, 1'b0);
    chk("rstmid_isTrap", isTrap, 1'b0);
    chk("rstmid_csr_we", csr_except_we, 1'b0);
    chk("rstmid_privileged_pc", privileged_pc, 64'd0);
    chk("rstmid_mcause", mcause_except_in, 64'd0);
    chk("rstmid_state", fsmState, ST_RUN);
    chk("rstmid_instret", instret_cnt, 64'd0);
    exp_q.delete();
    trap_q.delete();
    in_redirect = 1'b0;
    exp_instret = '0;
    @(negedge CLK);
    RSTn = 1'b1;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rand_inputs();
      commit_cycle();
    end
    next_cycle(); quiet_inputs(); commit_cycle();
    next_cycle(); quiet_inputs(); commit_cycle();
    @(negedge CLK);
    #1;
    chk("pending_exp", exp_q.size(), 0);
    chk("pending_trap", trap_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
